boid_frame_writer: RTL and testbench

BOID_FRAME_WRITER -- requirements
Module: boid_frame_writer

---
 rtl/boid_frame_writer.sv | 115 +++++++++++
 tb/tb_boid_frame_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/boid_frame_writer.sv
// rtl/boid_frame_writer.sv - scans boid coordinates once per frame and writes their pixels to display memory
module boid_frame_writer #(
    parameter int MAX_BOIDS    = 32,
    parameter int VIDEO_WIDTH  = 640,
    parameter int VIDEO_HEIGHT = 480,
    parameter int ADDR_WIDTH   = 19,
    localparam int SEL_W       = $clog2(MAX_BOIDS),
    localparam int SKIP_W      = SEL_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_end,
    output logic [SEL_W-1:0]      boid_sel,
    input  logic [9:0]            x_loc,
    input  logic [8:0]            y_loc,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_data,
    output logic                  clear_bank,
    output logic                  busy,
    output logic [SKIP_W-1:0]     skipped,
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DRAIN} state_t;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(MAX_BOIDS - 1);
    localparam logic [9:0]       X_LIM    = 10'(VIDEO_WIDTH);
    localparam logic [8:0]       Y_LIM    = 9'(VIDEO_HEIGHT);

    state_t                  state, next_state;
    logic                    frame_end_q;
    logic                    armed;
    logic                    start;
    logic                    sample_q;
    logic                    drain_last;
    logic                    on_screen;
    logic [SKIP_W-1:0]       skip_cnt;
    logic [ADDR_WIDTH-1:0]   x_ext, y_ext, pix_addr;

    // armed blocks a frame_end that is already high when reset releases
    assign start     = frame_end & ~frame_end_q & armed;
    assign wr_data   = wr_en;
    assign x_ext     = ADDR_WIDTH'(x_loc);
    assign y_ext     = ADDR_WIDTH'(y_loc);
    assign on_screen = (x_loc < X_LIM) && (y_loc < Y_LIM);

    generate
        if (VIDEO_WIDTH == 640) begin : g_addr_640
            assign pix_addr = (y_ext << 9) + (y_ext << 7) + x_ext;
        end else begin : g_addr_mul
            assign pix_addr = y_ext * ADDR_WIDTH'(VIDEO_WIDTH) + x_ext;
        end
    endgenerate

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        clear_bank = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = CLEAR;
            end
            CLEAR: begin
                clear_bank = 1'b1;
                next_state = SCAN;
            end
            SCAN:  if (boid_sel == LAST_SEL) next_state = DRAIN;
            DRAIN: if (drain_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            frame_end_q <= 1'b0;
            armed       <= 1'b0;
            boid_sel    <= '0;
            sample_q    <= 1'b0;
            drain_last  <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            skip_cnt    <= '0;
            skipped     <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= next_state;
            frame_end_q <= frame_end;
            if (!frame_end) armed <= 1'b1;
            if (start && state != IDLE) overrun <= 1'b1;

            // SCAN's first cycle repeats boid 0 already requested in CLEAR
            case (next_state)
                SCAN:    boid_sel <= (state == SCAN) ? boid_sel + SEL_W'(1) : '0;
                DRAIN:   boid_sel <= boid_sel;
                default: boid_sel <= '0;
            endcase

            // coordinates for the boid requested last cycle are valid now
            sample_q   <= (state == SCAN);
            wr_en      <= sample_q && on_screen;
            if (sample_q && on_screen) wr_addr <= pix_addr;
            drain_last <= (state == DRAIN) && !drain_last;

            if (state == CLEAR)
                skip_cnt <= '0;
            else if (sample_q && !on_screen)
                skip_cnt <= skip_cnt + SKIP_W'(1);
            if (state == DRAIN && next_state == IDLE) skipped <= skip_cnt;
        end
    end

endmodule

// File: tb/tb_boid_frame_writer.sv
// tb/tb_boid_frame_writer.sv - randomized self-checking bench for boid_frame_writer
module tb_boid_frame_writer;
    localparam int MB     = 32;
    localparam int SEL_W  = 5;
    localparam int SKIP_W = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic              frame_end;
    logic [SEL_W-1:0]  boid_sel;
    logic [9:0]        x_loc;
    logic [8:0]        y_loc;
    logic              wr_en;
    logic [18:0]       wr_addr;
    logic              wr_data;
    logic              clear_bank;
    logic              busy;
    logic [SKIP_W-1:0] skipped;
    logic              overrun;

    int checks = 0;
    int errors = 0;
    int x_tab[MB];
    int y_tab[MB];
    int clear_cnt, busy_cnt, clear_cyc, proto_err, cyc;
    int wq_addr[$];
    int wq_cyc[$];

    boid_frame_writer dut (
        .clock(clock), .reset(reset), .frame_end(frame_end), .boid_sel(boid_sel),
        .x_loc(x_loc), .y_loc(y_loc), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .clear_bank(clear_bank), .busy(busy),
        .skipped(skipped), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // coordinate memory: one cycle of read latency after boid_sel
    always @(posedge clock) begin
        x_loc <= 10'(x_tab[boid_sel]);
        y_loc <= 9'(y_tab[boid_sel]);
    end

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (clear_bank) begin
                clear_cnt++;
                clear_cyc = cyc;
            end
            if (busy) busy_cnt++;
            if (wr_en) begin
                wq_addr.push_back(int'(wr_addr));
                wq_cyc.push_back(cyc);
            end
            if (wr_data !== wr_en || (wr_en && (!busy || clear_bank))) proto_err++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        clear_cnt = 0; busy_cnt = 0; proto_err = 0; clear_cyc = 0;
        wq_addr.delete();
        wq_cyc.delete();
    endtask

    task automatic fill_rand(input int off_pct);
        for (int i = 0; i < MB; i++) begin
            if (i > 0 && $urandom_range(3) == 0) begin
                x_tab[i] = x_tab[i-1];
                y_tab[i] = y_tab[i-1];
            end else if ($urandom_range(99) < off_pct) begin
                x_tab[i] = $urandom_range(1023);
                y_tab[i] = $urandom_range(511);
            end else begin
                x_tab[i] = $urandom_range(639);
                y_tab[i] = $urandom_range(479);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!busy && n < 20) begin @(negedge clock); #1; n++; end
        check_val({tag, "_busy_rise"}, 32'(busy), 1);
        n = 0;
        while (busy && n < 200) begin @(negedge clock); #1; n++; end
        check_val({tag, "_busy_fall"}, 32'(busy), 0);
    endtask

    task automatic check_frame(input string tag);
        int exp_addr[$];
        int exp_skip = 0;
        for (int i = 0; i < MB; i++) begin
            if (x_tab[i] < 640 && y_tab[i] < 480) exp_addr.push_back(x_tab[i] + 640 * y_tab[i]);
            else exp_skip++;
        end
        check_val({tag, "_clears"}, clear_cnt, 1);
        check_val({tag, "_busy_cycles"}, busy_cnt, MB + 3);
        check_val({tag, "_nwrites"}, wq_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < wq_addr.size(); i++)
            check_val($sformatf("%s_addr%0d", tag, i), wq_addr[i], exp_addr[i]);
        check_val({tag, "_skipped"}, 32'(skipped), exp_skip);
        check_val({tag, "_protocol"}, proto_err, 0);
    endtask

    task automatic run_frame(input string tag);
        clear_mon();
        @(negedge clock); #1 frame_end = 1'b1;
        wait_idle(tag);
        frame_end = 1'b0;
        repeat (2) @(negedge clock);
        #1 check_frame(tag);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_sel"}, 32'(boid_sel), 0);
        check_val({tag, "_wr_en"}, 32'(wr_en), 0);
        check_val({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check_val({tag, "_clear_bank"}, 32'(clear_bank), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_skipped"}, 32'(skipped), 0);
        check_val({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    initial begin
        int n;
        cyc = 0;
        clear_mon();
        for (int i = 0; i < MB; i++) begin x_tab[i] = 0; y_tab[i] = 0; end
        reset = 1'b1;
        frame_end = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // linear placement: boid i at (10i, 5i)
        for (int i = 0; i < MB; i++) begin x_tab[i] = i * 10; y_tab[i] = i * 5; end
        run_frame("linear");
        check_val("linear_boid3", (wq_addr.size() > 3) ? wq_addr[3] : -1, 9630);
        check_val("linear_lat0", (wq_cyc.size() > 0) ? wq_cyc[0] - clear_cyc : -1, 3);
        check_val("linear_lat3", (wq_cyc.size() > 3) ? wq_cyc[3] - clear_cyc : -1, 6);
        check_val("linear_overrun", 32'(overrun), 0);

        // screen corners
        fill_rand(0);
        x_tab[0] = 639; y_tab[0] = 479;
        x_tab[1] = 0;   y_tab[1] = 0;
        run_frame("corner");
        check_val("corner_max", (wq_addr.size() > 0) ? wq_addr[0] : -1, 307199);
        check_val("corner_zero", (wq_addr.size() > 1) ? wq_addr[1] : -1, 0);

        // off-screen on both edges
        fill_rand(0);
        x_tab[5] = 640; x_tab[7] = 640; y_tab[9] = 480;
        run_frame("offscreen");
        check_val("offscreen_n", wq_addr.size(), 29);
        check_val("offscreen_skip", 32'(skipped), 3);

        for (int f = 0; f < 4; f++) begin
            fill_rand(30);
            run_frame($sformatf("rand%0d", f));
        end

        // second rise while busy is ignored and flagged
        fill_rand(0);
        clear_mon();
        @(negedge clock); #1 frame_end = 1'b1;
        repeat (3) @(negedge clock);
        #1 frame_end = 1'b0;
        repeat (7) @(negedge clock);
        #1 frame_end = 1'b1;
        wait_idle("overrun");
        frame_end = 1'b0;
        repeat (2) @(negedge clock);
        #1 check_frame("overrun");
        check_val("overrun_flag", 32'(overrun), 1);
        fill_rand(20);
        run_frame("after_overrun");
        check_val("overrun_sticky", 32'(overrun), 1);

        // reset in the middle of a scan, released with frame_end still high
        fill_rand(0);
        @(negedge clock); #1 frame_end = 1'b1;
        n = 0;
        while (boid_sel != 5'd12 && n < 60) begin @(negedge clock); #1; n++; end
        check_val("midreset_reach12", 32'(boid_sel), 12);
        reset = 1'b1;
        #1 check_zero_outputs("midreset");
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        clear_mon();
        repeat (20) @(negedge clock);
        #1;
        check_val("midreset_writes", wq_addr.size(), 0);
        check_val("midreset_clears", clear_cnt, 0);
        check_val("midreset_busy", busy_cnt, 0);
        frame_end = 1'b0;
        repeat (2) @(negedge clock);
        fill_rand(25);
        run_frame("after_reset");

        // a long frame_end level starts exactly one frame
        fill_rand(25);
        clear_mon();
        @(negedge clock); #1 frame_end = 1'b1;
        repeat (1000) @(negedge clock);
        #1 frame_end = 1'b0;
        repeat (2) @(negedge clock);
        #1 check_frame("long_level");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
